// File: rtl/shiftreg_seq.sv
// Command sequencer for an 8-bit universal shift register: accepts one command,
// then steps the register through a parallel load and N shifts, and returns the result.
module shiftreg_seq #(
  parameter int MAXCNT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_dir,
  input  logic [3:0] cmd_count,
  input  logic       cmd_rot,
  input  logic       cmd_fill,
  input  logic       abort,
  output logic [1:0] sr_s,
  output logic [7:0] sr_a,
  output logic       sr_shiftIn,
  input  logic [7:0] sr_q,
  output logic       busy,
  output logic       done,
  output logic [7:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  state_t     state, state_next;
  logic [7:0] data_q;
  logic       dir_q, rot_q, fill_q;
  logic [3:0] count_q;
  logic [3:0] cnt;
  logic       handshake;
  logic       finish;

  assign handshake = cmd_valid && cmd_ready;
  // A command that is aborted while in DONE must not publish its result.
  assign finish    = (state == DONE) && !abort;
  assign sr_a      = data_q;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    sr_s       = MODE_HOLD;
    sr_shiftIn = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = LOAD;
      end
      LOAD: begin
        sr_s       = MODE_LOAD;
        state_next = (count_q != 4'd0) ? SHIFT : DONE;
      end
      SHIFT: begin
        sr_s       = dir_q ? MODE_LEFT : MODE_RIGHT;
        sr_shiftIn = rot_q ? (dir_q ? sr_q[7] : sr_q[0]) : fill_q;
        if (cnt == 4'd1) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort && state != IDLE) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      fill_q  <= 1'b0;
      count_q <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      state <= state_next;
      done  <= finish;
      if (finish) result <= sr_q;
      if (handshake) begin
        data_q  <= cmd_data;
        dir_q   <= cmd_dir;
        rot_q   <= cmd_rot;
        fill_q  <= cmd_fill;
        count_q <= cmd_count;
      end
      if (state == LOAD) cnt <= count_q;
      else if (state == SHIFT) cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_shiftreg_seq.sv
// Directed bench for shiftreg_seq; a behavioural universal shift register closes the loop on sr_q.
module tb_shiftreg_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = '0;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_count = '0;
  logic       cmd_rot = 1'b0;
  logic       cmd_fill = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] sr_s;
  logic [7:0] sr_a;
  logic       sr_shiftIn;
  logic [7:0] sr_q = '0;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_result = '0;

  always #5 clk = ~clk;

  shiftreg_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .cmd_rot   (cmd_rot),
    .cmd_fill  (cmd_fill),
    .abort     (abort),
    .sr_s      (sr_s),
    .sr_a      (sr_a),
    .sr_shiftIn(sr_shiftIn),
    .sr_q      (sr_q),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  // The shift register being sequenced.
  always @(posedge clk) begin
    case (sr_s)
      2'b00:   sr_q <= sr_a;
      2'b01:   sr_q <= {sr_shiftIn, sr_q[7:1]};
      2'b10:   sr_q <= {sr_q[6:0], sr_shiftIn};
      default: sr_q <= sr_q;
    endcase
  end

  task automatic run_cmd(input string name, input logic [7:0] d, input logic dir,
                         input logic [3:0] n, input logic rot, input logic fill,
                         input logic [7:0] exp);
    logic [1:0] exp_s;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_data = d; cmd_dir = dir; cmd_count = n;
    cmd_rot = rot; cmd_fill = fill;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      exp_s = (c == 1) ? 2'b00 : (c <= n + 1) ? (dir ? 2'b10 : 2'b01) : 2'b11;
      checks++;
      if (sr_s !== exp_s || busy !== 1'b1 || done !== 1'b0 || sr_a !== d) begin
        errors++;
        $display("FAIL %s cycle %0d: sr_s=%b busy=%b done=%b sr_a=%h want sr_s=%b busy=1 done=0 sr_a=%h",
                 name, c, sr_s, busy, done, sr_a, exp_s, d);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || result !== exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done cycle %0d: done=%b result=%h busy=%b want done=1 result=%h busy=0",
               name, n + 3, done, result, busy, exp);
    end
    last_result = exp;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL %s after done: done=%b result=%h want done=0 result=%h", name, done, result, exp);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (sr_s !== 2'b11 || sr_a !== 8'h00 || sr_shiftIn !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || result !== 8'h00 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: sr_s=%b sr_a=%h sin=%b busy=%b done=%b result=%h ready=%b want 11 00 0 0 0 00 1",
               sr_s, sr_a, sr_shiftIn, busy, done, result, cmd_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'h5A; cmd_dir = 1'b0; cmd_count = 4'd8;
    cmd_rot = 1'b1; cmd_fill = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || sr_s !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_pre: busy=%b sr_s=%b want busy=1 sr_s=01", busy, sr_s);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (sr_s !== 2'b11 || sr_a !== 8'h00 || sr_shiftIn !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || result !== 8'h00 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_values: sr_s=%b sr_a=%h sin=%b busy=%b done=%b result=%h ready=%b",
               sr_s, sr_a, sr_shiftIn, busy, done, result, cmd_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_after: saw done/busy after reset release, want idle");
    end
  endtask

  task automatic test_right_logical();
    run_cmd("right_logical", 8'hAA, 1'b0, 4'd1, 1'b0, 1'b0, 8'h55);
  endtask

  task automatic test_left_fill();
    run_cmd("left_fill", 8'hAA, 1'b1, 4'd1, 1'b0, 1'b1, 8'h55);
  endtask

  task automatic test_rotate_right();
    run_cmd("rotate_right", 8'h81, 1'b0, 4'd3, 1'b1, 1'b0, 8'h30);
  endtask

  task automatic test_rotate_left();
    run_cmd("rotate_left8", 8'h81, 1'b1, 4'd8, 1'b1, 1'b0, 8'h81);
  endtask

  task automatic test_zero_count();
    run_cmd("zero_count", 8'h3C, 1'b0, 4'd0, 1'b0, 1'b1, 8'h3C);
  endtask

  task automatic test_max_count();
    run_cmd("max_count_fill", 8'h00, 1'b0, 4'd15, 1'b0, 1'b1, 8'hFF);
  endtask

  task automatic test_abort();
    logic seen;
    logic [7:0] prev;
    prev = last_result;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'hFF; cmd_dir = 1'b0; cmd_count = 4'd8;
    cmd_rot = 1'b0; cmd_fill = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || sr_s !== 2'b01) begin
      errors++;
      $display("FAIL abort_pre: busy=%b sr_s=%b want busy=1 sr_s=01", busy, sr_s);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || sr_s !== 2'b11 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b sr_s=%b ready=%b done=%b want 0 11 1 0", busy, sr_s, cmd_ready, done);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || result !== prev) begin
      errors++;
      $display("FAIL abort_after: seen_activity=%b result=%h want 0 %h", seen, result, prev);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'hAA; cmd_dir = 1'b0; cmd_count = 4'd1;
    cmd_rot = 1'b0; cmd_fill = 1'b0;
    @(negedge clk);
    cmd_data = 8'h81; cmd_dir = 1'b1; cmd_count = 4'd2; cmd_rot = 1'b1;
    checks++;
    if (busy !== 1'b1 || sr_s !== 2'b00 || sr_a !== 8'hAA) begin
      errors++;
      $display("FAIL b2b_first_load: busy=%b sr_s=%b sr_a=%h want 1 00 aa", busy, sr_s, sr_a);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 8'h55 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b result=%h ready=%b want 1 55 1", done, result, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || sr_s !== 2'b00 || sr_a !== 8'h81 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_load: busy=%b sr_s=%b sr_a=%h done=%b want 1 00 81 0", busy, sr_s, sr_a, done);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 8'h06) begin
      errors++;
      $display("FAIL b2b_second_done: done=%b result=%h want 1 06", done, result);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_right_logical();
    test_left_fill();
    test_rotate_right();
    test_rotate_left();
    test_max_count();
    test_zero_count();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
